// File: rtl/pipeline_issue_ctrl_pkg.sv
// Shared types and defaults for the pipeline issue/retire controller.
package pipeline_issue_ctrl_pkg;

    localparam int N_DEF     = 10;
    localparam int LAT_DEF   = 3;
    localparam int DEPTH_DEF = 4;
    localparam int TAGW_DEF  = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pipeline_issue_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear; head is visible while rd_vld.
// Latency: write visible the cycle after the push edge; clear takes priority over push and pop.
module pipeline_issue_ctrl_sync_fifo
    import pipeline_issue_ctrl_pkg::*;
#(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [cnt_w(DEPTH)-1:0]  cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, full;

    assign rd_vld = (cnt_q != '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign push   = wr_vld & ~clr;
    assign pop    = rd_vld & rd_rdy & ~clr;
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
    assign cnt    = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: rd_dat is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

    // The issue credit rule guarantees a free slot for every capture.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issues operand tuples into a fixed-latency pipeline, tags them, and returns F through a result FIFO.
// Latency LAT+1 cycles accept->out_valid; credit-gated in_ready so a stalled consumer never loses a result.
module pipeline_issue_ctrl
    import pipeline_issue_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAGW  = TAGW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic [N-1:0]    in_c,
    input  logic [N-1:0]    in_d,
    output logic [N-1:0]    p_a,
    output logic [N-1:0]    p_b,
    output logic [N-1:0]    p_c,
    output logic [N-1:0]    p_d,
    input  logic [N-1:0]    p_f,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_f,
    output logic [TAGW-1:0] out_tag,
    input  logic            flush,
    output logic            busy
);

    localparam int CW = cnt_w(DEPTH);

    state_t                   state_q, state_d;
    logic [N-1:0]             p_a_q, p_a_d, p_b_q, p_b_d, p_c_q, p_c_d, p_d_q, p_d_d;
    logic [LAT:0]             vld_sr_q, vld_sr_d;
    logic [LAT:0][TAGW-1:0]   tag_sr_q, tag_sr_d;
    logic [TAGW-1:0]          tag_q, tag_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic [CW-1:0]            fifo_cnt;
    logic [N+TAGW-1:0]        fifo_rd_dat;
    logic                     credit_ok, issue, capture, fifo_wr, fifo_clr;

    // Widened by one bit so the sum cannot wrap before the compare.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH);
    assign in_ready  = rst_n & (state_q == ST_RUN) & ~flush & credit_ok;
    assign issue     = in_valid & in_ready;
    assign capture   = vld_sr_q[LAT];
    assign fifo_clr  = flush & (state_q == ST_RUN);
    assign fifo_wr   = capture & (state_q == ST_RUN) & ~flush;

    always_comb begin
        p_a_d = issue ? in_a : p_a_q;
        p_b_d = issue ? in_b : p_b_q;
        p_c_d = issue ? in_c : p_c_q;
        p_d_d = issue ? in_d : p_d_q;
        tag_d = issue ? tag_q + TAGW'(1) : tag_q;

        vld_sr_d    = {vld_sr_q[LAT-1:0], issue};
        tag_sr_d    = tag_sr_q;
        tag_sr_d[0] = tag_q;
        for (int i = 1; i <= LAT; i++) tag_sr_d[i] = tag_sr_q[i-1];

        unique case ({issue, capture})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (flush) state_d = ST_FLUSH;
            ST_FLUSH: if (inflight_q == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            p_a_q      <= '0;
            p_b_q      <= '0;
            p_c_q      <= '0;
            p_d_q      <= '0;
            vld_sr_q   <= '0;
            tag_sr_q   <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            p_a_q      <= p_a_d;
            p_b_q      <= p_b_d;
            p_c_q      <= p_c_d;
            p_d_q      <= p_d_d;
            vld_sr_q   <= vld_sr_d;
            tag_sr_q   <= tag_sr_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    pipeline_issue_ctrl_sync_fifo #(
        .W     (N + TAGW),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (fifo_clr),
        .wr_vld (fifo_wr),
        .wr_dat ({tag_sr_q[LAT], p_f}),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (fifo_rd_dat),
        .cnt    (fifo_cnt)
    );

    assign p_a     = p_a_q;
    assign p_b     = p_b_q;
    assign p_c     = p_c_q;
    assign p_d     = p_d_q;
    assign out_f   = fifo_rd_dat[N-1:0];
    assign out_tag = fifo_rd_dat[N +: TAGW];
    assign busy    = (inflight_q != '0) | (fifo_cnt != '0) | (state_q == ST_FLUSH);

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl with a 3-stage F = A*B + C*D pipeline model and a result scoreboard.
module tb_pipeline_issue_ctrl;

    localparam int N    = 10;
    localparam int TAGW = 4;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [N-1:0]    f;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N-1:0]    in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic [N-1:0]    p_a, p_b, p_c, p_d, p_f;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    out_f;
    logic [TAGW-1:0] out_tag;
    logic            flush = 1'b0;
    logic            busy;

    logic [N-1:0]    pf1, pf2, pf3;
    exp_t            sb[$];
    logic [TAGW-1:0] exp_tag = '0;
    logic [TAGW-1:0] last_tag = '0;
    int              pops = 0;
    int              n_chk = 0;
    int              n_pass = 0;

    always #5 clk = ~clk;

    pipeline_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .p_a       (p_a),
        .p_b       (p_b),
        .p_c       (p_c),
        .p_d       (p_d),
        .p_f       (p_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_tag   (out_tag),
        .flush     (flush),
        .busy      (busy)
    );

    function automatic logic [N-1:0] golden(input logic [N-1:0] a, b, c, d);
        logic [2*N-1:0] t;
        t = (2*N)'(a) * (2*N)'(b) + (2*N)'(c) * (2*N)'(d);
        return t[N-1:0];
    endfunction

    // Pipeline: samples p_* one edge after issue, F valid LAT=3 edges later; never reset.
    always @(posedge clk) begin
        pf1 <= golden(p_a, p_b, p_c, p_d);
        pf2 <= pf1;
        pf3 <= pf2;
    end
    assign p_f = pf3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Scoreboard: push at accept, pop/compare at result handshake, dropped on flush or reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_tag = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("sb_f", 32'(out_f), 32'(e.f));
                    check_eq("sb_tag", 32'(out_tag), 32'(e.tag));
                    last_tag = out_tag;
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{tag: exp_tag, f: golden(in_a, in_b, in_c, in_d)});
                exp_tag = exp_tag + 1'b1;
            end
            if (flush) sb.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Presents a tuple and returns #1 after the accepting edge with in_valid still high.
    task automatic send(input logic [N-1:0] a, b, c, d);
        int n = 0;
        in_a = a; in_b = b; in_c = c; in_d = d; in_valid = 1'b1;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
        step();
    endtask

    task automatic wait_ov(input string tag, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin step(); cyc++; end
        check_eq(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin step(); n++; end
        step();
        check_eq(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int cyc, acc, cnt, p0;
        logic [N-1:0] t10 [4][4];
        t10 = '{'{10, 5, 8, 3}, '{15, 7, 12, 4}, '{20, 10, 14, 6}, '{25, 12, 18, 8}};

        // Reset state
        step(); step();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_f", 32'(out_f), 32'd0);
        check_eq("rst_out_tag", 32'(out_tag), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_p_a", 32'(p_a), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: single op latency
        out_ready = 1'b1;
        check_eq("t1_in_ready", 32'(in_ready), 32'd1);
        send(10, 5, 8, 3);
        in_valid = 1'b0;
        wait_ov("t1_ov", cyc);
        check_eq("t1_latency", 32'(cyc), 32'd4);
        check_eq("t1_f", 32'(out_f), 32'd74);
        check_eq("t1_tag", 32'(out_tag), 32'd0);
        drain("t1_drain");

        // 2: four back-to-back
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_in_ready", 32'(in_ready), 32'd1);
            send(t10[i][0], t10[i][1], t10[i][2], t10[i][3]);
        end
        in_valid = 1'b0;
        wait_ov("t2_ov", cyc);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_consec", 32'(out_valid), 32'd1);
            step();
        end
        check_eq("t2_ov_end", 32'(out_valid), 32'd0);
        drain("t2_drain");

        // 3: consumer stalled, credit limit
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_a = N'(30 + i); in_b = N'(3 + i); in_c = N'(7 * i); in_d = N'(i);
            in_valid = 1'b1;
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        check_eq("t3_accepts", 32'(acc), 32'd4);
        check_eq("t3_in_ready_lo", 32'(in_ready), 32'd0);
        check_eq("t3_ov", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        check_eq("t3_ready_before_pop", 32'(in_ready), 32'd0);
        step();
        check_eq("t3_ready_after_pop", 32'(in_ready), 32'd1);
        drain("t3_drain");

        // 4: flush with ops in flight
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(t10[i][0], t10[i][1], t10[i][2], t10[i][3]);
        in_valid = 1'b0;
        cnt = 0;
        if (out_valid) cnt++;
        step();
        flush = 1'b1;
        if (out_valid) cnt++;
        step();
        flush = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            if (out_valid) cnt++;
            cyc++;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            if (out_valid) cnt++;
            step();
        end
        check_eq("t4_busy_cycles", 32'(cyc), 32'd3);
        check_eq("t4_no_ov", 32'(cnt), 32'd0);
        check_eq("t4_run_ready", 32'(in_ready), 32'd1);
        send(7, 9, 11, 13);
        in_valid = 1'b0;
        wait_ov("t4_ov", cyc);
        check_eq("t4_tag", 32'(out_tag), 32'd3);
        check_eq("t4_f", 32'(out_f), 32'(golden(7, 9, 11, 13)));
        drain("t4_drain");

        // 5: tag wrap over 17 ops
        do_reset();
        out_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 17; i++) send(N'(i + 1), N'(2 * i + 1), N'(100 - i), N'(i * 3));
        in_valid = 1'b0;
        drain("t5_drain");
        check_eq("t5_count", 32'(pops - p0), 32'd17);
        check_eq("t5_last_tag", 32'(last_tag), 32'd0);

        // 6: reset with results in flight and buffered
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(t10[i][0], t10[i][1], t10[i][2], t10[i][3]);
        in_valid = 1'b0;
        step(); step();
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        check_eq("t6_ov", 32'(out_valid), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_p_a", 32'(p_a), 32'd0);
        check_eq("t6_p_d", 32'(p_d), 32'd0);
        check_eq("t6_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) cnt++;
            step();
        end
        check_eq("t6_no_stale", 32'(cnt), 32'd0);
        send(3, 4, 5, 6);
        in_valid = 1'b0;
        wait_ov("t6_ov_new", cyc);
        check_eq("t6_tag", 32'(out_tag), 32'd0);
        check_eq("t6_f", 32'(out_f), 32'(golden(3, 4, 5, 6)));
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
